systolic_result_unloader: RTL and testbench

Result-side consumer of the systolic array controller's done pulse. On done it snapshots the flattened N×N accumulator matrix. It then streams the matrix out one row per beat over a valid/ready interface. While it is busy it reports back-pressure upstream so that a new start is not issued while a snapshot is still being read out.

---
 rtl/systolic_result_unloader.sv | 158 +++++++++++++++
 tb/tb_systolic_result_unloader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_unloader.sv
// ----------------------------------------------------------------------------
// systolic_result_unloader
//
// Snapshots the flattened N x N accumulator matrix when the array controller
// pulses done_in. The snapshot is then streamed out one beat per handshake
// over a valid/ready interface, so a matrix takes N beats. While a snapshot
// is still being read out, capture_ready is held low so that a new start is
// not issued upstream.
//
// Optional build macro: UNLOADER_TRANSPOSE_EN
//   undefined (default) : beat k carries row k    (lane j = element (k,j))
//   defined             : beat k carries column k (lane j = element (j,k))
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset, highest priority
//   done_in       in   one-cycle pulse, acc_in is valid in that cycle
//   acc_in        in   N*N*ACC_WIDTH, element (r,c) at (r*N+c)*ACC_WIDTH
//   capture_ready out  a done_in in this cycle will be captured
//                      (combinational from out_ready)
//   out_valid     out  beat valid
//   out_ready     in   downstream accepts the beat
//   out_data      out  N*ACC_WIDTH, lane j at j*ACC_WIDTH
//   out_row       out  beat index 0..N-1
//   out_last      out  high with beat N-1
//   overrun       out  sticky, done_in arrived while capture_ready was low
//   overrun_clr   in   clears overrun (a simultaneous new overrun wins)
// ----------------------------------------------------------------------------
module systolic_result_unloader #(
   parameter int ARRAY_SIZE = 4,
   parameter int ACC_WIDTH  = 32
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      done_in,
   input  logic [ARRAY_SIZE*ARRAY_SIZE*ACC_WIDTH-1:0] acc_in,
   output logic                                      capture_ready,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic [ARRAY_SIZE*ACC_WIDTH-1:0]           out_data,
   output logic [$clog2(ARRAY_SIZE)-1:0]             out_row,
   output logic                                      out_last,
   output logic                                      overrun,
   input  logic                                      overrun_clr
);

   localparam int N  = ARRAY_SIZE;
   localparam int W  = ACC_WIDTH;
   localparam int CW = $clog2(ARRAY_SIZE);
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } state_t;

   state_t               state_r;
   logic [N*N*W-1:0]     snap_r;
   logic [CW-1:0]        cnt_r;
   logic                 at_last_s;

   // Extracts the lanes of beat k from a flattened matrix.
   function automatic logic [N*W-1:0] select_beat(input logic [N*N*W-1:0] m,
                                                  input logic [CW-1:0]    k);
      logic [N*W-1:0] beat;
      beat = '0;
      for (int j = 0; j < N; j++) begin
`ifdef UNLOADER_TRANSPOSE_EN
         beat[j*W +: W] = m[(j*N + int'(k))*W +: W];
`else
         beat[j*W +: W] = m[(int'(k)*N + j)*W +: W];
`endif
      end
      return beat;
   endfunction

   // The final beat of a matrix is presented this cycle.
   assign at_last_s = (state_r == S_STREAM) && (cnt_r == LAST_IDX);

   // Capture is possible when idle, or when the final beat hands off this
   // cycle so the next matrix follows without a bubble.
   assign capture_ready = (state_r == S_IDLE) || (at_last_s && out_ready);

   // Unloader FSM, snapshot, beat counter, registered outputs and sticky overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= S_IDLE;
         snap_r    <= '0;
         cnt_r     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_row   <= '0;
         out_last  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         // Set has priority over clear so no overrun event is ever lost.
         if (done_in && !capture_ready) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end else begin
            overrun <= overrun;
         end

         case (state_r)
            S_IDLE: begin
               if (done_in) begin
                  state_r   <= S_STREAM;
                  snap_r    <= acc_in;
                  cnt_r     <= '0;
                  out_valid <= 1'b1;
                  out_data  <= select_beat(acc_in, CW'(0));
                  out_row   <= '0;
                  out_last  <= (LAST_IDX == CW'(0));
               end else begin
                  state_r   <= S_IDLE;
                  out_valid <= 1'b0;
               end
            end
            S_STREAM: begin
               if (out_ready && at_last_s) begin
                  if (done_in) begin
                     // Back-to-back matrix: reload straight into beat 0.
                     state_r   <= S_STREAM;
                     snap_r    <= acc_in;
                     cnt_r     <= '0;
                     out_valid <= 1'b1;
                     out_data  <= select_beat(acc_in, CW'(0));
                     out_row   <= '0;
                     out_last  <= (LAST_IDX == CW'(0));
                  end else begin
                     state_r   <= S_IDLE;
                     cnt_r     <= '0;
                     out_valid <= 1'b0;
                     out_data  <= '0;
                     out_row   <= '0;
                     out_last  <= 1'b0;
                  end
               end else if (out_ready) begin
                  cnt_r    <= cnt_r + CW'(1);
                  out_data <= select_beat(snap_r, cnt_r + CW'(1));
                  out_row  <= cnt_r + CW'(1);
                  out_last <= ((cnt_r + CW'(1)) == LAST_IDX);
               end else begin
                  // Back-pressure: every beat output holds.
                  cnt_r <= cnt_r;
               end
            end
            default: begin
               state_r   <= S_IDLE;
               cnt_r     <= '0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_result_unloader.sv
// ----------------------------------------------------------------------------
// Testbench for systolic_result_unloader. A transaction-level reference
// model keeps a queue of the beats still owed downstream: an accepted
// done_in appends N beats computed from the element matrix, and each
// handshake retires the front beat. Directed scenarios are followed by a
// randomized phase.
// ----------------------------------------------------------------------------
module tb_systolic_result_unloader;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int CW = $clog2(N);

   typedef struct {
      logic [N*W-1:0] data;
      int             row;
      bit             last;
   } beat_t;

   logic                 clk;
   logic                 rst;
   logic                 done_in;
   logic [N*N*W-1:0]     acc_in;
   logic                 capture_ready;
   logic                 out_valid;
   logic                 out_ready;
   logic [N*W-1:0]       out_data;
   logic [CW-1:0]        out_row;
   logic                 out_last;
   logic                 overrun;
   logic                 overrun_clr;

   int n_compared = 0;
   int n_mismatched = 0;

   logic [W-1:0] elem [N][N];
   beat_t        exp_q [$];
   bit           ovr_m;
   bit           known;
   bit           just_reset;

   systolic_result_unloader #(.ARRAY_SIZE(N), .ACC_WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .done_in      (done_in),
      .acc_in       (acc_in),
      .capture_ready(capture_ready),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_row      (out_row),
      .out_last     (out_last),
      .overrun      (overrun),
      .overrun_clr  (overrun_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic fill_pattern(input int base);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            elem[r][c] = W'(base + 16 * r + c);
   endtask

   task automatic fill_random();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            elem[r][c] = $urandom;
   endtask

   // Appends the N beats of the current element matrix to the expected queue.
   task automatic push_matrix();
      beat_t b;
      for (int k = 0; k < N; k++) begin
         b.data = '0;
         for (int j = 0; j < N; j++) begin
`ifdef UNLOADER_TRANSPOSE_EN
            b.data[j*W +: W] = elem[j][k];
`else
            b.data[j*W +: W] = elem[k][j];
`endif
         end
         b.row  = k;
         b.last = (k == N - 1);
         exp_q.push_back(b);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance the model.
   task automatic step(input bit d, input bit rd, input bit clr, input bit r);
      bit cap_ok;
      @(negedge clk);
      done_in     = d;
      out_ready   = rd;
      overrun_clr = clr;
      rst         = r;
      for (int i = 0; i < N; i++)
         for (int c = 0; c < N; c++)
            acc_in[(i*N + c)*W +: W] = elem[i][c];
      #1;
      cap_ok = (exp_q.size() == 0) || (exp_q.size() == 1 && rd);
      if (known) begin
         if (exp_q.size() == 0) begin
            check("out_valid_idle", 256'(out_valid), 256'(1'b0));
         end else begin
            check("out_valid", 256'(out_valid), 256'(1'b1));
            check("out_data", 256'(out_data), 256'(exp_q[0].data));
            check("out_row", 256'(out_row), 256'(exp_q[0].row));
            check("out_last", 256'(out_last), 256'(exp_q[0].last));
         end
         check("overrun", 256'(overrun), 256'(ovr_m));
         check("capture_ready", 256'(capture_ready), 256'(cap_ok));
         if (just_reset) begin
            check("rst_out_data", 256'(out_data), 256'(0));
            check("rst_out_row", 256'(out_row), 256'(0));
            check("rst_out_last", 256'(out_last), 256'(1'b0));
         end
      end
      just_reset = 1'b0;
      if (r) begin
         exp_q.delete();
         ovr_m      = 1'b0;
         known      = 1'b1;
         just_reset = 1'b1;
      end else begin
         if (d && !cap_ok) ovr_m = 1'b1;
         else if (clr)     ovr_m = 1'b0;
         if (exp_q.size() > 0 && rd) void'(exp_q.pop_front());
         if (d && cap_ok) push_matrix();
      end
   endtask

   initial begin
      rst = 1'b1; done_in = 1'b0; out_ready = 1'b0; overrun_clr = 1'b0;
      acc_in = '0; ovr_m = 1'b0; known = 1'b0; just_reset = 1'b0;
      fill_pattern(0);

      // Reset, then basic readout with out_ready held high.
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 1, 0, 0);

      // Back-pressure: out_ready low for three cycles during beat 1.
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0);

      // Back-to-back: second done_in on beat 3's handshake.
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      fill_pattern(100);
      step(1, 1, 0, 0);
      fill_pattern(0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0);

      // Overrun: done_in while beat 1 is pending, then clear it.
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      fill_pattern(200);
      step(1, 0, 0, 0);
      fill_pattern(0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
      step(0, 1, 1, 0);
      step(0, 1, 0, 0);

      // Reset mid-stream during beat 2, then a clean restart.
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 1);
      step(0, 1, 0, 0);
      fill_pattern(300);
      step(1, 1, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 1, 0, 0);

      // Randomized phase.
      for (int i = 0; i < 600; i++) begin
         fill_random();
         step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0);
      end
      step(0, 1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
